// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, receiver state encoding and
// the bit-shifting helper used by both the receiver and the transmitter.
package uart_pkg;

   localparam int OVS = 16;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_t;

   function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] cur, input logic bit_in);
      return {bit_in, cur[7:1]};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a full FIFO still accepts a push
// when a pop happens in the same cycle, otherwise the push is dropped.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     valid_o,
   output logic                     drop_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             empty_s, full_s, do_push_s, do_pop_s;

   always_comb begin
      empty_s   = (cnt_q == '0);
      full_s    = (cnt_q == FULL_CNT);
      do_pop_s  = pop_i & ~empty_s;
      do_push_s = push_i & (~full_s | do_pop_s);
      drop_o    = push_i & ~do_push_s;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; the head output is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = empty_s ? '0 : mem_q[rd_ptr_q];
   assign valid_o = ~empty_s;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a receive FIFO, with
// framing-error pulse and sticky overflow flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int OVS        = uart_pkg::OVS
) (
   input  logic                          clk_sys,
   input  logic                          rst_sys,
   input  logic                          RX,
   input  logic [15:0]                   baud_div,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic                          frm_err,
   output logic                          ovf_err,
   input  logic                          err_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam logic [3:0] MID_TICK  = 4'(OVS / 2 - 1);
   localparam logic [3:0] LAST_TICK = 4'(OVS - 1);

   logic        rx_meta_q, rx_sync_q;
   logic [1:0]  fill_q, fill_d;
   logic        seen_high_q, seen_high_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic [15:0] div_q, div_d;
   logic        tick_s;
   rx_state_t   state_q, state_d;
   logic [3:0]  ovs_cnt_q, ovs_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        frm_err_q, frm_err_d;
   logic        ovf_err_q, ovf_err_d;
   logic        push_s, drop_s;

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
      end
   end

   // A start is only accepted once the line has been seen idle after reset,
   // so a reset in the middle of a frame cannot trigger on the leftover low.
   always_comb begin
      tick_s      = (tick_cnt_q == div_q);
      tick_cnt_d  = tick_s ? 16'd0 : tick_cnt_q + 16'd1;
      div_d       = tick_s ? baud_div : div_q;
      fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      seen_high_d = seen_high_q | (tick_s & rx_sync_q & (fill_q == 2'd2));
   end

   always_comb begin
      state_d   = state_q;
      ovs_cnt_d = ovs_cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      push_s    = 1'b0;
      frm_err_d = 1'b0;
      if (tick_s) begin
         case (state_q)
            RX_IDLE: begin
               if (~rx_sync_q & seen_high_q) begin
                  state_d   = RX_START;
                  ovs_cnt_d = 4'd0;
               end else begin
                  state_d = RX_IDLE;
               end
            end
            RX_START: begin
               if (ovs_cnt_q == MID_TICK) begin
                  ovs_cnt_d = 4'd0;
                  bit_idx_d = 3'd0;
                  state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  ovs_cnt_d = ovs_cnt_q + 4'd1;
               end
            end
            RX_DATA: begin
               if (ovs_cnt_q == LAST_TICK) begin
                  ovs_cnt_d = 4'd0;
                  shreg_d   = shift_in_lsb_first(shreg_q, rx_sync_q);
                  bit_idx_d = bit_idx_q + 3'd1;
                  state_d   = (bit_idx_q == 3'd7) ? RX_STOP : RX_DATA;
               end else begin
                  ovs_cnt_d = ovs_cnt_q + 4'd1;
               end
            end
            RX_STOP: begin
               if (ovs_cnt_q == LAST_TICK) begin
                  ovs_cnt_d = 4'd0;
                  if (rx_sync_q) begin
                     push_s  = 1'b1;
                     state_d = RX_IDLE;
                  end else begin
                     frm_err_d = 1'b1;
                     state_d   = RX_WAIT_IDLE;
                  end
               end else begin
                  ovs_cnt_d = ovs_cnt_q + 4'd1;
               end
            end
            RX_WAIT_IDLE: begin
               if (rx_sync_q) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_WAIT_IDLE;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Set wins over clear so an overflow in the clearing cycle is not lost.
   always_comb begin
      ovf_err_d = drop_s | (ovf_err_q & ~err_clr);
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         fill_q      <= 2'd0;
         seen_high_q <= 1'b0;
         tick_cnt_q  <= 16'd0;
         div_q       <= baud_div;
         state_q     <= RX_IDLE;
         ovs_cnt_q   <= 4'd0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'd0;
         frm_err_q   <= 1'b0;
         ovf_err_q   <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         seen_high_q <= seen_high_d;
         tick_cnt_q  <= tick_cnt_d;
         div_q       <= div_d;
         state_q     <= state_d;
         ovs_cnt_q   <= ovs_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         frm_err_q   <= frm_err_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk_sys),
      .rst         (rst_sys),
      .push_i      (push_s),
      .push_data_i (shreg_q),
      .pop_i       (rd_ready),
      .head_o      (rd_data),
      .valid_o     (rd_valid),
      .drop_o      (drop_s),
      .cnt_o       (fifo_cnt)
   );

   assign frm_err = frm_err_q;
   assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frames are driven bit by bit, expected
// bytes are queued when sent and compared as the consumer pops them.
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk_sys = 1'b0;
   logic          rst_sys;
   logic          RX;
   logic [15:0]   baud_div;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic          frm_err;
   logic          ovf_err;
   logic          err_clr;
   logic [CW-1:0] fifo_cnt;

   int checks  = 0;
   int errors  = 0;
   int frm_cnt = 0;
   int bit_cycles;
   logic [7:0] exp_q[$];

   uart_rx_fifo #(
      .FIFO_DEPTH (DEPTH),
      .OVS        (16)
   ) dut (
      .clk_sys  (clk_sys),
      .rst_sys  (rst_sys),
      .RX       (RX),
      .baud_div (baud_div),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .frm_err  (frm_err),
      .ovf_err  (ovf_err),
      .err_clr  (err_clr),
      .fifo_cnt (fifo_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Pops happen on the rising edge after rd_valid & rd_ready is seen here.
   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk_sys);
         if (frm_err === 1'b1) frm_cnt++;
         if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: got %h, required no byte", rd_data);
            end else begin
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  errors++;
                  $display("FAIL pop_data: got %h required %h", rd_data, e);
               end
            end
         end
      end
   endtask

   task automatic send_bit(input logic b);
      RX = b;
      cyc(bit_cycles);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         cyc(1);
         n++;
      end
      cyc(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_sys  = 1'b1;
      RX       = 1'b1;
      rd_ready = 1'b0;
      err_clr  = 1'b0;
      baud_div = 16'd7;
      cyc(4);
      checks += 4;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
      if (fifo_cnt !== '0)   begin errors++; $display("FAIL reset_fifo_cnt: got %0d required 0", fifo_cnt); end
      if (frm_err !== 1'b0)  begin errors++; $display("FAIL reset_frm_err: got %b required 0", frm_err); end
      if (ovf_err !== 1'b0)  begin errors++; $display("FAIL reset_ovf_err: got %b required 0", ovf_err); end
      rst_sys = 1'b0;
      cyc(2 * bit_cycles);
   endtask

   task automatic test_basic();
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      cyc(4);
      checks += 4;
      if (rd_valid !== 1'b1)  begin errors++; $display("FAIL basic_rd_valid: got %b required 1", rd_valid); end
      if (rd_data !== 8'h55)  begin errors++; $display("FAIL basic_rd_data: got %h required 55", rd_data); end
      if (fifo_cnt !== CW'(1)) begin errors++; $display("FAIL basic_fifo_cnt: got %0d required 1", fifo_cnt); end
      if (frm_cnt != 0)       begin errors++; $display("FAIL basic_frm_err: got %0d pulses required 0", frm_cnt); end
      rd_ready = 1'b1;
      wait_drain("basic");
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      vals = '{8'h00, 8'hFF, 8'hA5};
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(vals[i]);
         send_frame(vals[i], 1'b1);
      end
      wait_drain("b2b");
      checks += 2;
      if (fifo_cnt !== '0) begin errors++; $display("FAIL b2b_fifo_cnt: got %0d required 0", fifo_cnt); end
      if (frm_cnt != 0)    begin errors++; $display("FAIL b2b_frm_err: got %0d pulses required 0", frm_cnt); end
   endtask

   task automatic test_overflow();
      rd_ready = 1'b0;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         if (i <= DEPTH) exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1);
      end
      cyc(4);
      checks += 2;
      if (fifo_cnt !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_fifo_cnt: got %0d required %0d", fifo_cnt, DEPTH); end
      if (ovf_err !== 1'b1)        begin errors++; $display("FAIL ovf_set: got %b required 1", ovf_err); end
      rd_ready = 1'b1;
      wait_drain("ovf");
      checks += 2;
      if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", ovf_err); end
      if (fifo_cnt !== '0)  begin errors++; $display("FAIL ovf_drained_cnt: got %0d required 0", fifo_cnt); end
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      cyc(1);
      checks++;
      if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", ovf_err); end
   endtask

   task automatic test_frame_error();
      int f0;
      f0 = frm_cnt;
      rd_ready = 1'b1;
      send_frame(8'h3C, 1'b0);
      RX = 1'b0;
      cyc(3 * bit_cycles);
      RX = 1'b1;
      cyc(2 * bit_cycles);
      checks += 2;
      if (frm_cnt != f0 + 1) begin errors++; $display("FAIL frm_pulse_count: got %0d required %0d", frm_cnt - f0, 1); end
      if (fifo_cnt !== '0)   begin errors++; $display("FAIL frm_no_push: got %0d required 0", fifo_cnt); end
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_drain("frm_recover");
      checks++;
      if (frm_cnt != f0 + 1) begin errors++; $display("FAIL frm_recover_err: got %0d pulses required 1", frm_cnt - f0); end
   endtask

   task automatic test_glitch();
      int f0;
      f0 = frm_cnt;
      rd_ready = 1'b1;
      RX = 1'b0;
      cyc(4 * (int'(baud_div) + 1));
      RX = 1'b1;
      cyc(3 * bit_cycles);
      checks += 2;
      if (fifo_cnt !== '0) begin errors++; $display("FAIL glitch_no_push: got %0d required 0", fifo_cnt); end
      if (frm_cnt != f0)   begin errors++; $display("FAIL glitch_no_err: got %0d pulses required 0", frm_cnt - f0); end
   endtask

   task automatic test_reset_midframe();
      int f0;
      logic [7:0] d;
      d = 8'h81;
      f0 = frm_cnt;
      rd_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      exp_q.push_back(8'h22);
      send_frame(8'h22, 1'b1);
      cyc(4);
      checks++;
      if (fifo_cnt !== CW'(2)) begin errors++; $display("FAIL rst_mid_queued: got %0d required 2", fifo_cnt); end
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      RX = d[4];
      cyc(bit_cycles / 2);
      rst_sys = 1'b1;
      cyc(2);
      rst_sys = 1'b0;
      exp_q.delete();
      cyc(1);
      checks += 2;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_valid: got %b required 0", rd_valid); end
      if (fifo_cnt !== '0)   begin errors++; $display("FAIL rst_mid_fifo_cnt: got %0d required 0", fifo_cnt); end
      cyc(bit_cycles - bit_cycles / 2 - 3);
      for (int i = 5; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      cyc(bit_cycles);
      checks += 2;
      if (fifo_cnt !== '0) begin errors++; $display("FAIL rst_mid_no_push: got %0d required 0", fifo_cnt); end
      if (frm_cnt != f0)   begin errors++; $display("FAIL rst_mid_no_err: got %0d pulses required 0", frm_cnt - f0); end
      rd_ready = 1'b1;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      wait_drain("rst_mid_after");
   endtask

   initial begin
      bit_cycles = 16 * 8;
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_frame_error();
      test_glitch();
      test_reset_midframe();
      cyc(10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter OVS, default 16, oversampling ticks per bit (fixed 16; other values unsupported).
REQ-003 SHALL have port clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_sys  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port RX  in  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port baud_div  in  16  tick period minus one; a tick occurs every baud_div+1 clk_sys cycles.
REQ-007 SHALL have port rd_data  out  8  FIFO head byte, valid while rd_valid=1.
REQ-008 SHALL have port rd_valid  out  1  FIFO not empty.
REQ-009 SHALL have port rd_ready  in  1  consumer accepts head byte.
REQ-010 SHALL have port frm_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port ovf_err  out  1  sticky: byte dropped, FIFO full.
REQ-012 SHALL have port err_clr  in  1  clears ovf_err.
REQ-013 SHALL have port fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-014 SHALL pass RX through a 2-FF synchronizer (reset value 1) before any use; 2-cycle input latency.
REQ-015 SHALL run a tick counter: reload 0, tick when counter=baud_div, then wrap to 0; free-running, not restarted on start bit; baud_div changes take effect at the next wrap.
REQ-016 SHALL implement FSM IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: synchronized RX low on a tick -> START, tick count cleared.
REQ-018 START: after 8 ticks, sample RX; low -> DATA, high -> IDLE (glitch rejected, no error).
REQ-019 DATA: sample every 16 ticks; shift into data register LSB first; after bit 7 -> STOP.
REQ-020 STOP: sample after 16 ticks; high -> push byte, -> IDLE; low -> discard byte, pulse frm_err, -> WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until RX high on a tick, then -> IDLE (break condition yields exactly one frm_err).
REQ-022 Push SHALL occur in the same cycle the stop bit is sampled high; rd_valid rises on the following cycle.
REQ-023 Pop SHALL occur when rd_valid & rd_ready; rd_data updates to next entry on the following cycle.
REQ-024 Push while full and no pop SHALL drop the new byte, leave FIFO unchanged, set ovf_err.
REQ-025 Push and pop in same cycle while full SHALL both succeed; fifo_cnt unchanged, no overflow.
REQ-026 Push and pop in same cycle while empty: pop ignored (rd_valid=0), push succeeds.
REQ-027 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-028 err_clr coinciding with a new overflow SHALL leave ovf_err set (set wins).
REQ-029 rd_ready with rd_valid=0 SHALL have no effect.

Reset
REQ-030 On rst_sys: FSM=IDLE, tick counter=0, synchronizer=1, pointers=0, fifo_cnt=0, rd_valid=0, frm_err=0, ovf_err=0; rd_data don't-care but driven.
REQ-031 Reset mid-frame SHALL abandon the frame without push or error; first frame after reset requires a fresh falling edge.

Structure
REQ-032 SHALL place OVS constant and the FSM state enum (rx_state_t) in shared package uart_pkg, reused by the transmitter.
REQ-033 SHALL instantiate one sub-module sync_fifo (parameters WIDTH=8, DEPTH=FIFO_DEPTH) holding storage, pointers, count.

Verification
REQ-034 baud_div=7 at 14.7456 MHz (115200 baud), send 0x55 -> rd_data=0x55, rd_valid=1, frm_err never set.
REQ-035 Send 0x00,0xFF,0xA5 back-to-back, rd_ready=1 -> three bytes in order, fifo_cnt returns to 0.
REQ-036 rd_ready=0, send 9 bytes 0x01..0x09, depth 8 -> fifo_cnt=8, ovf_err=1, reads yield 0x01..0x08; err_clr -> ovf_err=0.
REQ-037 Send 0x3C with stop bit low, then line low 3 bit times -> one frm_err pulse, no push; next valid 0x3C received correctly.
REQ-038 RX low pulse of 4 ticks -> no START->DATA transition, no push, no error.
REQ-039 Assert rst_sys during bit 4 of 0x81 with 2 bytes queued -> rd_valid=0, fifo_cnt=0; subsequent 0x81 received intact.
